// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with byte enables and write scoreboard (optional REGS_BYPASS_EN write-through)
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     rw,
    input  logic [DATA_W-1:0]     din,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]     rs,
    input  logic [ADDR_W-1:0]     rt,
    output logic [DATA_W-1:0]     a,
    output logic [DATA_W-1:0]     b,
    input  logic                  iss,
    input  logic [ADDR_W-1:0]     iss_rd,
    output logic                  busy_rs,
    output logic                  busy_rt,
    output logic [CNT_W-1:0]      pend_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wr_go;
    logic              iss_go;

    // Register 0 is never a legal destination for either a write or a reservation.
    assign wr_go  = we && (rw != '0);
    assign iss_go = iss && (iss_rd != '0);

    // Next busy vector: writeback clears, issue sets; a same-edge issue wins over the clear.
    always_comb begin
        busy_nxt = busy;
        if (wr_go) begin
            busy_nxt[rw] = 1'b0;
        end
        if (iss_go) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector so pend_cnt moves on the same edge as busy.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    // Register array, busy bits and pending count; byte-masked writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
            if (wr_go) begin
                for (int i = 0; i < NB; i++) begin
                    if (wbe[i]) begin
                        regs[rw][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef REGS_BYPASS_EN
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] nw,
                                                input logic [NB-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = nw[8*i +: 8];
            end
        end
        return r;
    endfunction

    logic hit_a;
    logic hit_b;
    assign hit_a = wr_go && (rw == rs);
    assign hit_b = wr_go && (rw == rt);

    // Read ports with same-cycle write-through; a completing write hides the busy bit
    // unless the same register is being re-reserved this cycle. Held at zero during reset.
    always_comb begin
        a       = '0;
        b       = '0;
        busy_rs = 1'b0;
        busy_rt = 1'b0;
        if (!rst) begin
            if (rs != '0) a = hit_a ? merge(regs[rs], din, wbe) : regs[rs];
            if (rt != '0) b = hit_b ? merge(regs[rt], din, wbe) : regs[rt];
            busy_rs = busy[rs] && !(hit_a && !(iss && (iss_rd == rs)));
            busy_rt = busy[rt] && !(hit_b && !(iss && (iss_rd == rt)));
        end
    end
`else
    // Read ports show stored state only; register 0 forced to zero.
    always_comb begin
        a       = (rs == '0) ? '0 : regs[rs];
        b       = (rt == '0) ? '0 : regs[rt];
        busy_rs = busy[rs];
        busy_rt = busy[rt];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb with a behavioural reference model
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        we, iss, busy_rs, busy_rt;
    logic [4:0]  rw, rs, rt, iss_rd;
    logic [31:0] din, a, b;
    logic [3:0]  wbe;
    logic [5:0]  pend_cnt;

    // DATA_W=64, ADDR_W=3 instance
    logic        we2, iss2, busy_rs2, busy_rt2;
    logic [2:0]  rw2, rs2, rt2, iss_rd2;
    logic [63:0] din2, a2, b2;
    logic [7:0]  wbe2;
    logic [3:0]  pend_cnt2;

    regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .rw(rw), .din(din), .wbe(wbe),
        .rs(rs), .rt(rt), .a(a), .b(b), .iss(iss), .iss_rd(iss_rd),
        .busy_rs(busy_rs), .busy_rt(busy_rt), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.DATA_W(64), .ADDR_W(3)) dut2 (
        .clk(clk), .rst(rst), .we(we2), .rw(rw2), .din(din2), .wbe(wbe2),
        .rs(rs2), .rt(rt2), .a(a2), .b(b2), .iss(iss2), .iss_rd(iss_rd2),
        .busy_rs(busy_rs2), .busy_rt(busy_rt2), .pend_cnt(pend_cnt2)
    );

`ifdef REGS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mreg  [32];
    bit          mbusy [32];
    logic [63:0] mreg2 [8];
    bit          mbusy2[8];

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    function automatic int mcount2();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(mbusy2[i]);
        return c;
    endfunction

    // What a read port should show right now, given the currently driven inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (BYP && we && rw == r) return bmerge(mreg[r], din, wbe);
        return mreg[r];
    endfunction

    function automatic bit exp_busy(input logic [4:0] r);
        if (BYP && we && rw != 0 && rw == r && !(iss && iss_rd == r)) return 1'b0;
        return mbusy[r];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin mreg[i] = '0; mbusy[i] = 0; end
        for (int i = 0; i < 8; i++) begin mreg2[i] = '0; mbusy2[i] = 0; end
    endtask

    task automatic idle();
        we = 0; rw = 0; din = 0; wbe = 0; iss = 0; iss_rd = 0;
        we2 = 0; rw2 = 0; din2 = 0; wbe2 = 0; iss2 = 0; iss_rd2 = 0;
    endtask

    // Advance one clock, applying the architectural rules to the model at the edge.
    task automatic tick();
        @(posedge clk);
        if (we && rw != 0) begin
            mreg[rw] = bmerge(mreg[rw], din, wbe);
            mbusy[rw] = 0;
        end
        if (iss && iss_rd != 0) mbusy[iss_rd] = 1;
        if (we2 && rw2 != 0) begin
            for (int i = 0; i < 8; i++) if (wbe2[i]) mreg2[rw2][8*i +: 8] = din2[8*i +: 8];
            mbusy2[rw2] = 0;
        end
        if (iss2 && iss_rd2 != 0) mbusy2[iss_rd2] = 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); rs = 5'd7; rt = 5'd9; rs2 = 3'd3; rt2 = 3'd4;
        model_clear();
        @(negedge clk);
        total++; if (a !== 32'h0 || b !== 32'h0) begin bad++; $display("FAIL reset_ab a=%h b=%h want 0", a, b); end
        total++; if (busy_rs !== 1'b0 || busy_rt !== 1'b0) begin bad++; $display("FAIL reset_busy rs=%b rt=%b want 0", busy_rs, busy_rt); end
        total++; if (pend_cnt !== 6'd0 || pend_cnt2 !== 4'd0) begin bad++; $display("FAIL reset_cnt %0d/%0d want 0", pend_cnt, pend_cnt2); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_rw();
        idle();
        we = 1; rw = 16; din = 15; wbe = 4'hF; tick();
        rw = 17; din = 25; tick();
        rw = 0; din = 666; tick();
        idle(); rs = 16; rt = 17; #1;
        total++; if (a !== 32'd15) begin bad++; $display("FAIL basic_a got %0d want 15", a); end
        total++; if (b !== 32'd25) begin bad++; $display("FAIL basic_b got %0d want 25", b); end
        rs = 0; rt = 0; #1;
        total++; if (a !== 32'd0 || b !== 32'd0) begin bad++; $display("FAIL reg0 a=%0d b=%0d want 0", a, b); end
        rs = 17; rt = 17; #1;
        total++; if (a !== 32'd25 || b !== 32'd25) begin bad++; $display("FAIL same_addr a=%0d b=%0d want 25", a, b); end
    endtask

    task automatic test_byte_enables();
        idle();
        we = 1; rw = 18; din = 32'hAABBCCDD; wbe = 4'hF; tick();
        din = 32'h11223344; wbe = 4'b0101; tick();
        din = 32'h55555555; wbe = 4'b0000; tick();
        idle(); rs = 18; #1;
        total++; if (a !== 32'hAA22CC44) begin bad++; $display("FAIL byte_en got %h want aa22cc44", a); end
    endtask

    task automatic test_scoreboard();
        idle();
        iss = 1; iss_rd = 5; tick();
        iss_rd = 6; tick();
        idle(); rs = 5; rt = 6; #1;
        total++; if (pend_cnt !== 6'd2) begin bad++; $display("FAIL sb_cnt2 got %0d want 2", pend_cnt); end
        total++; if (busy_rs !== 1'b1 || busy_rt !== 1'b1) begin bad++; $display("FAIL sb_busy rs=%b rt=%b want 1", busy_rs, busy_rt); end
        we = 1; rw = 5; wbe = 4'h0; tick();
        idle(); #1;
        total++; if (busy_rs !== 1'b0 || pend_cnt !== 6'd1) begin bad++; $display("FAIL sb_clear busy=%b cnt=%0d want 0/1", busy_rs, pend_cnt); end
        iss = 1; iss_rd = 6; we = 1; rw = 6; din = 32'h77; wbe = 4'hF; tick();
        idle(); #1;
        total++; if (busy_rt !== 1'b1 || pend_cnt !== 6'd1) begin bad++; $display("FAIL sb_setwins busy=%b cnt=%0d want 1/1", busy_rt, pend_cnt); end
        iss = 1; iss_rd = 0; tick();
        iss_rd = 6; tick();
        idle(); #1;
        total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL sb_rd0_waw got %0d want 1", pend_cnt); end
        we = 1; rw = 8; din = 1; wbe = 4'hF; rs = 8; tick();
        idle(); #1;
        total++; if (busy_rs !== 1'b0 || pend_cnt !== 6'd1) begin bad++; $display("FAIL sb_nonbusy busy=%b cnt=%0d want 0/1", busy_rs, pend_cnt); end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; rw = 9; din = 0; wbe = 4'hF; tick();
        idle(); iss = 1; iss_rd = 9; tick();
        idle(); we = 1; rw = 9; din = 32'hDEADBEEF; wbe = 4'hF; rs = 9; #1;
        total++; if (a !== (BYP ? 32'hDEADBEEF : 32'h0)) begin bad++; $display("FAIL bypass_pre a=%h want %h", a, BYP ? 32'hDEADBEEF : 32'h0); end
        total++; if (busy_rs !== !BYP) begin bad++; $display("FAIL bypass_busy got %b want %b", busy_rs, !BYP); end
        tick();
        idle(); #1;
        total++; if (a !== 32'hDEADBEEF || busy_rs !== 1'b0) begin bad++; $display("FAIL bypass_post a=%h busy=%b want deadbeef/0", a, busy_rs); end
    endtask

    task automatic test_param_sweep();
        idle();
        we2 = 1; rw2 = 7; din2 = '1; wbe2 = 8'h80; tick();
        idle(); rs2 = 7; rt2 = 0; #1;
        total++; if (a2 !== 64'hFF00_0000_0000_0000) begin bad++; $display("FAIL sweep_be got %h want ff00000000000000", a2); end
        total++; if (b2 !== 64'h0) begin bad++; $display("FAIL sweep_r0 got %h want 0", b2); end
        for (int r = 1; r < 8; r++) begin
            iss2 = 1; iss_rd2 = 3'(r); tick();
        end
        idle(); #1;
        total++; if (pend_cnt2 !== 4'd7 || pend_cnt2 !== 4'(mcount2())) begin bad++; $display("FAIL sweep_cnt got %0d want 7", pend_cnt2); end
        total++; if (busy_rs2 !== 1'b1) begin bad++; $display("FAIL sweep_busy got %b want 1", busy_rs2); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            we = $urandom_range(0, 1); rw = 5'($urandom_range(0, 31));
            din = $urandom; wbe = 4'($urandom);
            iss = ($urandom_range(0, 2) == 0); iss_rd = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
            rt = ($urandom_range(0, 3) == 0) ? iss_rd : 5'($urandom);
            #1;
            total++;
            if (a !== exp_rd(rs) || b !== exp_rd(rt)) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_read n=%0d a=%h b=%h want %h %h", n, a, b, exp_rd(rs), exp_rd(rt));
            end
            total++;
            if (busy_rs !== exp_busy(rs) || busy_rt !== exp_busy(rt)) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_busy n=%0d got %b%b want %b%b", n, busy_rs, busy_rt, exp_busy(rs), exp_busy(rt));
            end
            tick();
            total++;
            if (pend_cnt !== 6'(mcount())) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_cnt n=%0d got %0d want %0d", n, pend_cnt, mcount());
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        we = 1; rw = 16; din = 32'h12345678; wbe = 4'hF; iss = 1; iss_rd = 16; tick();
        idle(); rs = 16; #1;
        total++; if (a !== 32'h12345678 || busy_rs !== 1'b1) begin bad++; $display("FAIL mid_pre a=%h busy=%b want 12345678/1", a, busy_rs); end
        @(negedge clk); rst = 1; #1;
        total++; if (a !== 32'h0 || busy_rs !== 1'b0 || pend_cnt !== 6'd0) begin bad++; $display("FAIL mid_reset a=%h busy=%b cnt=%0d want 0", a, busy_rs, pend_cnt); end
        model_clear();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_byte_enables();
        test_scoreboard();
        test_bypass();
        test_param_sweep();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
